// File: rtl/ct_l2c_prefetch_mq_pkg.sv
// ============================================================================
// Module      : ct_l2c_prefetch_mq_pkg
// Description : Shared prot encoding and per-entry field widths for the
//               multi-stream L2C next-line prefetcher.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ct_l2c_prefetch_mq_pkg;

  localparam int         c_rem_w     = 2;
  localparam logic [1:0] c_prot_lo   = 2'b11;
  localparam logic [2:0] c_prot_idle = 3'b111;

  // prot[2] marks an instruction-side request, so TLB walks clear it.
  function automatic logic [2:0] prf_prot(input logic tlb);
    return {~tlb, c_prot_lo};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ct_l2c_prefetch_mq_entry.sv
// ============================================================================
// Module      : ct_l2c_prefetch_mq_entry
// Description : One prefetch stream: valid/addr/tlb/remaining with advance,
//               retire-on-page-toggle and dedup compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ct_l2c_prefetch_mq_entry
  import ct_l2c_prefetch_mq_pkg::*;
#(
  parameter int ADDR_W   = 34,
  parameter int PAGE_BIT = 6
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst_b,
  input  logic                flush,
  input  logic                load,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic                load_tlb,
  input  logic [c_rem_w-1:0]  load_rem,
  input  logic                advance,
  input  logic [ADDR_W-1:0]   cmp_addr,
  output logic                valid,
  output logic [ADDR_W-1:0]   cur_addr,
  output logic                tlb,
  output logic                dedup_hit
);

  logic                r_valid;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_tlb;
  logic [c_rem_w-1:0]  r_rem;
  logic [ADDR_W-1:0]   w_next_addr;
  logic                w_retire;

  assign w_next_addr = r_addr + ADDR_W'(1);
  assign w_retire    = (r_rem == '0) | (w_next_addr[PAGE_BIT] != r_addr[PAGE_BIT]);

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_tlb   <= 1'b0;
      r_rem   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_addr  <= load_addr;
      r_tlb   <= load_tlb;
      r_rem   <= load_rem;
    end else if (advance) begin
      if (w_retire) begin
        r_valid <= 1'b0;
      end else begin
        r_addr <= w_next_addr;
        r_rem  <= r_rem - c_rem_w'(1);
      end
    end
  end

  assign valid     = r_valid;
  assign cur_addr  = r_addr;
  assign tlb       = r_tlb;
  assign dedup_hit = r_valid & (r_addr == cmp_addr);

endmodule

`default_nettype wire

// File: rtl/ct_l2c_prefetch_mq.sv
// ============================================================================
// Module      : ct_l2c_prefetch_mq
// Description : Multi-stream L2 next-line prefetcher: trigger qualification,
//               bank priority, stream allocation and round-robin CIU issue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ct_l2c_prefetch_mq
  import ct_l2c_prefetch_mq_pkg::*;
#(
  parameter int NUM_BANKS   = 2,
  parameter int BANK_BITS   = 1,
  parameter int ADDR_W      = 34,
  parameter int NUM_STREAMS = 4,
  parameter int PAGE_BIT    = 6
) (
  input  logic                                forever_cpuclk,
  input  logic                                cpurst_b,
  input  logic [1:0]                          ciu_l2c_iprf,
  input  logic                                ciu_l2c_tprf,
  input  logic                                ciu_l2c_prf_flush,
  input  logic                                ciu_l2c_prf_ready,
  input  logic [NUM_BANKS-1:0]                cmp_pref_vld,
  input  logic [NUM_BANKS-1:0]                cmp_pref_read,
  input  logic [NUM_BANKS-1:0]                cmp_pref_cache_miss,
  input  logic [NUM_BANKS-1:0]                cmp_pref_ifu_req,
  input  logic [NUM_BANKS-1:0]                cmp_pref_tlb_req,
  input  logic [NUM_BANKS*(ADDR_W-BANK_BITS)-1:0] cmp_pref_addr,
  output logic                                l2c_ciu_prf_vld,
  output logic [ADDR_W-1:0]                   l2c_ciu_prf_addr,
  output logic [2:0]                          l2c_ciu_prf_prot,
  output logic                                prf_idle,
  output logic                                prf_drop
);

  localparam int CMP_W = ADDR_W - BANK_BITS;
  localparam int PTR_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

  logic [NUM_BANKS-1:0]   w_trig;
  logic [ADDR_W-1:0]      w_full [NUM_BANKS];
  logic                   w_any_trig;
  logic                   w_multi_trig;
  logic [ADDR_W-1:0]      w_win_full;
  logic                   w_win_tlb;
  logic [ADDR_W-1:0]      w_first;
  logic                   w_page_ok;
  logic                   w_alloc;
  logic [c_rem_w-1:0]     w_load_rem;

  logic [NUM_STREAMS-1:0] w_ent_valid;
  logic [NUM_STREAMS-1:0] w_ent_tlb;
  logic [NUM_STREAMS-1:0] w_ent_hit;
  logic [ADDR_W-1:0]      w_ent_addr [NUM_STREAMS];

  logic                   w_free_any;
  logic [PTR_W-1:0]       w_free_idx;
  logic [PTR_W-1:0]       w_scan;
  logic [PTR_W-1:0]       w_pick;
  logic [PTR_W-1:0]       w_sel;
  logic                   w_any_vld;
  logic                   w_xfer;

  logic [PTR_W-1:0]       r_rr_ptr;
  logic                   r_lock;
  logic [PTR_W-1:0]       r_lock_sel;

  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      assign w_trig[b] = cmp_pref_vld[b] & cmp_pref_read[b] & cmp_pref_cache_miss[b] &
                         ((cmp_pref_ifu_req[b] & (ciu_l2c_iprf != 2'd0)) |
                          (cmp_pref_tlb_req[b] & ciu_l2c_tprf));
      assign w_full[b] = {cmp_pref_addr[b*CMP_W +: CMP_W], BANK_BITS'(b)};
    end
  endgenerate

  // Lowest triggering bank wins; any further trigger in the cycle is dropped.
  always_comb begin
    w_any_trig   = 1'b0;
    w_multi_trig = 1'b0;
    w_win_full   = '0;
    w_win_tlb    = 1'b0;
    for (int b = NUM_BANKS-1; b >= 0; b--) begin
      if (w_trig[b]) begin
        w_multi_trig = w_multi_trig | w_any_trig;
        w_any_trig   = 1'b1;
        w_win_full   = w_full[b];
        w_win_tlb    = cmp_pref_tlb_req[b];
      end
    end
  end

  assign w_first    = w_win_full + ADDR_W'(1);
  assign w_page_ok  = (w_first[PAGE_BIT] == w_win_full[PAGE_BIT]);
  assign w_load_rem = w_win_tlb ? '0 : (ciu_l2c_iprf - 2'd1);
  assign w_alloc    = w_any_trig & w_page_ok & ~(|w_ent_hit) & w_free_any & ~ciu_l2c_prf_flush;
  assign prf_drop   = w_multi_trig | (w_any_trig & ~w_alloc);

  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_STREAMS-1; i >= 0; i--) begin
      if (!w_ent_valid[i]) begin
        w_free_any = 1'b1;
        w_free_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    w_scan = '0;
    w_pick = '0;
    for (int k = NUM_STREAMS-1; k >= 0; k--) begin
      w_scan = PTR_W'((int'(r_rr_ptr) + k) % NUM_STREAMS);
      if (w_ent_valid[w_scan]) w_pick = w_scan;
    end
  end

  // A stalled request keeps its entry even if a new stream lands ahead of it.
  assign w_sel     = r_lock ? r_lock_sel : w_pick;
  assign w_any_vld = |w_ent_valid;
  assign w_xfer    = w_any_vld & ciu_l2c_prf_ready;

  generate
    for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_entry
      ct_l2c_prefetch_mq_entry #(
        .ADDR_W   (ADDR_W),
        .PAGE_BIT (PAGE_BIT)
      ) u_entry (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .flush          (ciu_l2c_prf_flush),
        .load           (w_alloc & (w_free_idx == PTR_W'(i))),
        .load_addr      (w_first),
        .load_tlb       (w_win_tlb),
        .load_rem       (w_load_rem),
        .advance        (w_xfer & (w_sel == PTR_W'(i))),
        .cmp_addr       (w_first),
        .valid          (w_ent_valid[i]),
        .cur_addr       (w_ent_addr[i]),
        .tlb            (w_ent_tlb[i]),
        .dedup_hit      (w_ent_hit[i])
      );
    end
  endgenerate

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      r_rr_ptr   <= '0;
      r_lock     <= 1'b0;
      r_lock_sel <= '0;
    end else begin
      if (w_xfer) begin
        r_rr_ptr <= (w_sel == PTR_W'(NUM_STREAMS-1)) ? '0 : (w_sel + PTR_W'(1));
      end
      r_lock     <= w_any_vld & ~ciu_l2c_prf_ready & ~ciu_l2c_prf_flush;
      r_lock_sel <= w_sel;
    end
  end

  assign l2c_ciu_prf_vld  = w_any_vld;
  assign l2c_ciu_prf_addr = w_any_vld ? w_ent_addr[w_sel] : '0;
  assign l2c_ciu_prf_prot = w_any_vld ? prf_prot(w_ent_tlb[w_sel]) : c_prot_idle;
  assign prf_idle         = ~w_any_vld;

endmodule

`default_nettype wire

// File: tb/tb_ct_l2c_prefetch_mq.sv
// ============================================================================
// Module      : tb_ct_l2c_prefetch_mq
// Description : Self-checking bench: vector table, directed corner sequences
//               and randomized traffic against a stream-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ct_l2c_prefetch_mq;

  localparam int NB = 2;
  localparam int AW = 34;
  localparam int CW = 33;
  localparam int NS = 4;

  logic            clk = 1'b0;
  logic            cpurst_b;
  logic [1:0]      iprf;
  logic            tprf, flush, ready;
  logic [NB-1:0]   c_vld, c_read, c_miss, c_ifu, c_tlb;
  logic [NB*CW-1:0] c_addr;
  logic            prf_vld;
  logic [AW-1:0]   prf_addr;
  logic [2:0]      prf_prot;
  logic            prf_idle, prf_drop;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ct_l2c_prefetch_mq dut (
    .forever_cpuclk      (clk),
    .cpurst_b            (cpurst_b),
    .ciu_l2c_iprf        (iprf),
    .ciu_l2c_tprf        (tprf),
    .ciu_l2c_prf_flush   (flush),
    .ciu_l2c_prf_ready   (ready),
    .cmp_pref_vld        (c_vld),
    .cmp_pref_read       (c_read),
    .cmp_pref_cache_miss (c_miss),
    .cmp_pref_ifu_req    (c_ifu),
    .cmp_pref_tlb_req    (c_tlb),
    .cmp_pref_addr       (c_addr),
    .l2c_ciu_prf_vld     (prf_vld),
    .l2c_ciu_prf_addr    (prf_addr),
    .l2c_ciu_prf_prot    (prf_prot),
    .prf_idle            (prf_idle),
    .prf_drop            (prf_drop)
  );

  typedef struct {
    logic [1:0]    iprf;
    bit            tprf;
    int            bank;
    logic [CW-1:0] addr;
    bit            ifu;
    bit            tlb;
    bit            exp_drop;
    int            exp_cnt;
    logic [AW-1:0] exp_first;
    logic [2:0]    exp_prot;
  } vec_t;

  vec_t vec [10];

  // Reference model: a set of streams, each a next address plus lines left.
  bit            m_v [NS];
  logic [AW-1:0] m_a [NS];
  bit            m_t [NS];
  int            m_r [NS];
  int            m_rr;
  bit            m_lock;
  int            m_lsel;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_trig();
    c_vld = '0; c_read = '0; c_miss = '0; c_ifu = '0; c_tlb = '0; c_addr = '0;
    flush = 1'b0;
  endtask

  task automatic set_bank(input int b, input logic [CW-1:0] a, input bit ifu, input bit tlb);
    c_vld[b] = 1'b1; c_read[b] = 1'b1; c_miss[b] = 1'b1;
    c_ifu[b] = ifu;  c_tlb[b] = tlb;
    c_addr[b*CW +: CW] = a;
  endtask

  task automatic do_reset();
    cpurst_b = 1'b0;
    clr_trig();
    tick();
    tick();
    cpurst_b = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_v[i] = 0; m_a[i] = '0; m_t[i] = 0; m_r[i] = 0;
    end
    m_rr = 0; m_lock = 0; m_lsel = 0;
  endtask

  task automatic model_cycle();
    bit any, hit, ok;
    int s, ntrig, win, fidx;
    logic [AW-1:0] full, first, nxt;
    any = 0;
    for (int i = 0; i < NS; i++) if (m_v[i]) any = 1;
    s = 0;
    if (m_lock) s = m_lsel;
    else for (int k = NS-1; k >= 0; k--) if (m_v[(m_rr+k)%NS]) s = (m_rr+k)%NS;
    chk("rnd_vld", prf_vld, any);
    chk("rnd_idle", prf_idle, !any);
    chk("rnd_addr", prf_addr, any ? m_a[s] : '0);
    chk("rnd_prot", prf_prot, any ? {!m_t[s], 2'b11} : 3'b111);
    ntrig = 0; win = -1; ok = 0; fidx = -1;
    for (int b = 0; b < NB; b++) begin
      if (c_vld[b] && c_read[b] && c_miss[b] && ((c_ifu[b] && iprf != 0) || (c_tlb[b] && tprf))) begin
        ntrig++;
        if (win < 0) win = b;
      end
    end
    if (ntrig > 0) begin
      full  = {c_addr[win*CW +: CW], 1'(win)};
      first = full + 1;
      hit   = 0;
      for (int i = 0; i < NS; i++) if (m_v[i] && m_a[i] == first) hit = 1;
      for (int i = NS-1; i >= 0; i--) if (!m_v[i]) fidx = i;
      ok = (first[6] == full[6]) && !hit && (fidx >= 0) && !flush;
    end
    chk("rnd_drop", prf_drop, (ntrig > 1) || (ntrig > 0 && !ok));
    if (flush) begin
      for (int i = 0; i < NS; i++) m_v[i] = 0;
      if (any && ready) m_rr = (s + 1) % NS;
      m_lock = 0;
    end else begin
      if (any && ready) begin
        nxt = m_a[s] + 1;
        if (m_r[s] == 0 || nxt[6] != m_a[s][6]) m_v[s] = 0;
        else begin
          m_a[s] = nxt;
          m_r[s] = m_r[s] - 1;
        end
        m_rr = (s + 1) % NS;
      end
      if (ok) begin
        m_v[fidx] = 1;
        m_a[fidx] = first;
        m_t[fidx] = c_tlb[win];
        m_r[fidx] = c_tlb[win] ? 0 : int'(iprf) - 1;
      end
      m_lock = any && !ready;
      m_lsel = s;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    vec[0] = '{2'd3, 1'b0, 0, 33'h10,  1'b1, 1'b0, 1'b0, 3, 34'h21,  3'b111};
    vec[1] = '{2'd0, 1'b1, 1, 33'h10,  1'b0, 1'b1, 1'b0, 1, 34'h22,  3'b011};
    vec[2] = '{2'd3, 1'b0, 0, 33'h1F,  1'b1, 1'b0, 1'b0, 1, 34'h3F,  3'b111};
    vec[3] = '{2'd3, 1'b0, 1, 33'h1F,  1'b1, 1'b0, 1'b1, 0, 34'h0,   3'b111};
    vec[4] = '{2'd0, 1'b0, 0, 33'h10,  1'b1, 1'b1, 1'b0, 0, 34'h0,   3'b111};
    vec[5] = '{2'd2, 1'b0, 0, 33'h100, 1'b1, 1'b0, 1'b0, 2, 34'h201, 3'b111};
    vec[6] = '{2'd3, 1'b1, 1, 33'h50,  1'b1, 1'b1, 1'b0, 1, 34'hA2,  3'b011};
    vec[7] = '{2'd1, 1'b0, 1, {CW{1'b1}}, 1'b1, 1'b0, 1'b1, 0, 34'h0, 3'b111};
    vec[8] = '{2'd3, 1'b0, 0, 33'h1E,  1'b1, 1'b0, 1'b0, 3, 34'h3D,  3'b111};
    vec[9] = '{2'd3, 1'b0, 0, 33'h1D,  1'b1, 1'b0, 1'b0, 3, 34'h3B,  3'b111};

    cpurst_b = 1'b0; iprf = 2'd0; tprf = 1'b0; ready = 1'b0;
    clr_trig();
    @(negedge clk);
    tick();
    tick();
    chk("rst_vld", prf_vld, 1'b0);
    chk("rst_addr", prf_addr, '0);
    chk("rst_prot", prf_prot, 3'b111);
    chk("rst_idle", prf_idle, 1'b1);
    chk("rst_drop", prf_drop, 1'b0);
    cpurst_b = 1'b1;

    // Single-trigger vectors with the CIU always ready.
    for (int v = 0; v < 10; v++) begin
      do_reset();
      iprf = vec[v].iprf; tprf = vec[v].tprf; ready = 1'b1;
      set_bank(vec[v].bank, vec[v].addr, vec[v].ifu, vec[v].tlb);
      #1 chk("tbl_drop", prf_drop, vec[v].exp_drop);
      tick();
      clr_trig();
      chk("tbl_lat", prf_vld, vec[v].exp_cnt != 0);
      cnt = 0;
      for (int c = 0; c < 6; c++) begin
        if (prf_vld) begin
          chk("tbl_addr", prf_addr, vec[v].exp_first + AW'(cnt));
          chk("tbl_prot", prf_prot, vec[v].exp_prot);
          cnt++;
        end
        tick();
      end
      chk("tbl_cnt", cnt, vec[v].exp_cnt);
      chk("tbl_idle", prf_idle, 1'b1);
    end

    // Four streams stalled, fifth dropped, then round-robin drain.
    do_reset();
    iprf = 2'd1; tprf = 1'b0; ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_bank(0, CW'((i + 1) * 'h100), 1'b1, 1'b0);
      #1 chk("full_alloc_drop", prf_drop, 1'b0);
      tick();
      clr_trig();
      chk("full_hold_addr", prf_addr, 34'h201);
    end
    set_bank(0, 33'h500, 1'b1, 1'b0);
    #1 chk("full_fifth_drop", prf_drop, 1'b1);
    tick();
    clr_trig();
    tick();
    chk("full_stall_vld", prf_vld, 1'b1);
    chk("full_stall_addr", prf_addr, 34'h201);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_addr", prf_addr, AW'((i + 1) * 'h200 + 1));
      tick();
    end
    chk("rr_idle", prf_idle, 1'b1);

    // Both banks trigger together, then a duplicate of the live stream.
    do_reset();
    iprf = 2'd3; ready = 1'b0;
    set_bank(0, 33'h10, 1'b1, 1'b0);
    set_bank(1, 33'h30, 1'b1, 1'b0);
    #1 chk("dual_drop", prf_drop, 1'b1);
    tick();
    clr_trig();
    chk("dual_addr", prf_addr, 34'h21);
    set_bank(0, 33'h10, 1'b1, 1'b0);
    #1 chk("dedup_drop", prf_drop, 1'b1);
    tick();
    clr_trig();
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("dedup_seq", prf_addr, AW'('h21 + i));
      tick();
    end
    chk("dedup_idle", prf_idle, 1'b1);

    // Flush under stall, then reset in the middle of a stream.
    do_reset();
    iprf = 2'd3; ready = 1'b0;
    set_bank(0, 33'h10, 1'b1, 1'b0);
    tick();
    clr_trig();
    chk("fl_pre_vld", prf_vld, 1'b1);
    flush = 1'b1;
    set_bank(1, 33'h40, 1'b1, 1'b0);
    #1 chk("fl_drop", prf_drop, 1'b1);
    tick();
    clr_trig();
    chk("fl_vld", prf_vld, 1'b0);
    chk("fl_idle", prf_idle, 1'b1);
    ready = 1'b1;
    set_bank(0, 33'h10, 1'b1, 1'b0);
    tick();
    clr_trig();
    chk("rs_first", prf_addr, 34'h21);
    tick();
    chk("rs_second", prf_addr, 34'h22);
    cpurst_b = 1'b0;
    tick();
    chk("rs_vld", prf_vld, 1'b0);
    chk("rs_addr", prf_addr, '0);
    chk("rs_prot", prf_prot, 3'b111);
    chk("rs_idle", prf_idle, 1'b1);
    chk("rs_drop", prf_drop, 1'b0);
    cpurst_b = 1'b1;

    // Randomized traffic against the stream model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 50 == 0) begin
        iprf = 2'($urandom_range(0, 3));
        tprf = 1'($urandom_range(0, 1));
      end
      for (int b = 0; b < NB; b++) begin
        c_vld[b]  = ($urandom_range(0, 2) == 0);
        c_read[b] = ($urandom_range(0, 3) != 0);
        c_miss[b] = ($urandom_range(0, 3) != 0);
        c_ifu[b]  = 1'($urandom_range(0, 1));
        c_tlb[b]  = 1'($urandom_range(0, 1));
        c_addr[b*CW +: CW] = CW'($urandom_range(0, 47));
      end
      ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 63) == 0);
      #1 model_cycle();
      tick();
    end
    clr_trig();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
